// File: rtl/cvxif_group_dispatch.sv
// -----------------------------------------------------------------------------
// cvxif_group_dispatch
//
// Dispatches CV-X-IF coprocessor instructions to NumGroups functional-unit
// groups and collects their results.
// - The opcode field [GroupSelLsb +: clog2(NumGroups)] selects the group.
//   Opcodes that select a group that does not exist are consumed and rejected.
// - Each group has a credit counter (0..Depth) and two FIFOs of depth Depth:
//   a tag FIFO of in-flight ids and a result FIFO of {id, data}.
// - Buffered results leave through one round-robin arbitrated valid/ready
//   port. The grant is held while the consumer stalls.
// - flush_i clears all in-flight and buffered state in one cycle.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   flush_i                 discard all in-flight and buffered state
//   issue_valid_i           instruction offered
//   issue_ready_o           instruction consumed this cycle
//   issue_accept_o          consumed instruction had a legal opcode
//   issue_opcode_i          opcode
//   issue_id_i              instruction id
//   issue_operands_i        two operands
//   grp_exec_o              one-hot execute strobe, same cycle as the handshake
//   grp_opcode_o            opcode broadcast to all groups
//   grp_operands_o          operand broadcast to all groups
//   grp_ready_i             per-group: can take a new exec
//   grp_flush_o             flush forwarded to the groups
//   grp_done_i              per-group result strobe, in issue order per group
//   grp_result_i            per-group result data
//   result_valid_o          result available
//   result_ready_i          consumer takes the result
//   result_id_o             id of the returned instruction
//   result_data_o           result data
//   result_group_o          group that produced the result
// -----------------------------------------------------------------------------
module cvxif_group_dispatch #(
    parameter int unsigned NumGroups   = 4,
    parameter int unsigned Depth       = 2,
    parameter int unsigned OpcodeWidth = 8,
    parameter int unsigned GroupSelLsb = 4,
    parameter int unsigned InWidth     = 32,
    parameter int unsigned OutWidth    = 32,
    parameter int unsigned IdWidth     = 3,
    localparam int unsigned GselW      = $clog2(NumGroups)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    output logic                          issue_accept_o,
    input  logic [OpcodeWidth-1:0]        issue_opcode_i,
    input  logic [IdWidth-1:0]            issue_id_i,
    input  logic [2*InWidth-1:0]          issue_operands_i,
    output logic [NumGroups-1:0]          grp_exec_o,
    output logic [OpcodeWidth-1:0]        grp_opcode_o,
    output logic [2*InWidth-1:0]          grp_operands_o,
    input  logic [NumGroups-1:0]          grp_ready_i,
    output logic                          grp_flush_o,
    input  logic [NumGroups-1:0]          grp_done_i,
    input  logic [NumGroups*OutWidth-1:0] grp_result_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [IdWidth-1:0]            result_id_o,
    output logic [OutWidth-1:0]           result_data_o,
    output logic [GselW-1:0]              result_group_o
);

    localparam int unsigned      CntW       = $clog2(Depth + 1);
    localparam int unsigned      PtrW       = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [GselW-1:0] LastGrpIdx = GselW'(NumGroups - 1);

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PtrW-1:0] ptr_t;

    // Wrapping pointer increment; Depth need not be a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        if (32'(p) == Depth - 1) return '0;
        return p + 1'b1;
    endfunction

    // Credits, FIFO occupancies and FIFO pointers, one set per group.
    cnt_t cnt_q  [NumGroups];
    cnt_t cnt_d  [NumGroups];
    cnt_t tcnt_q [NumGroups];
    cnt_t tcnt_d [NumGroups];
    cnt_t rcnt_q [NumGroups];
    cnt_t rcnt_d [NumGroups];
    ptr_t twr_q  [NumGroups];
    ptr_t twr_d  [NumGroups];
    ptr_t trd_q  [NumGroups];
    ptr_t trd_d  [NumGroups];
    ptr_t rwr_q  [NumGroups];
    ptr_t rwr_d  [NumGroups];
    ptr_t rrd_q  [NumGroups];
    ptr_t rrd_d  [NumGroups];

    logic [GselW-1:0] last_grant_q, last_grant_d;
    logic [GselW-1:0] lock_grp_q, lock_grp_d;
    logic             lock_q, lock_d;

    logic [IdWidth-1:0]  tag_mem  [NumGroups][Depth];
    logic [IdWidth-1:0]  rid_mem  [NumGroups][Depth];
    logic [OutWidth-1:0] rdat_mem [NumGroups][Depth];

    logic [GselW-1:0]     grp_sel;
    logic                 legal;
    logic                 room;
    logic                 issue_hs;
    logic                 res_hs;
    logic [NumGroups-1:0] done_eff;
    logic [NumGroups-1:0] res_pop;
    logic [GselW-1:0]     grant;
    logic                 grant_vld;
    int unsigned          rr_idx;

    assign grp_opcode_o   = issue_opcode_i;
    assign grp_operands_o = issue_operands_i;
    assign grp_flush_o    = flush_i;

    // ------------------------------------------------------------------ issue
    assign grp_sel = issue_opcode_i[GroupSelLsb +: GselW];

    // Compare against each existing group instead of indexing cnt_q with
    // grp_sel, which may point past the last group.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        legal = 1'b0;
        room  = 1'b0;
        for (int g = 0; g < NumGroups; g++) begin
            if (grp_sel == GselW'(g)) begin
                legal = 1'b1;
                room  = (cnt_q[g] < CntW'(Depth)) && grp_ready_i[g];
            end
        end
    end

    // rst_ni gates ready so that nothing is consumed while reset is applied.
    assign issue_ready_o  = rst_ni && !flush_i && (!legal || room);
    assign issue_hs       = issue_valid_i && issue_ready_o;
    assign issue_accept_o = issue_hs && legal;

    always_comb begin
        grp_exec_o = '0;
        for (int g = 0; g < NumGroups; g++) begin
            if (issue_accept_o && (grp_sel == GselW'(g))) grp_exec_o[g] = 1'b1;
        end
    end

    // ------------------------------------------------------------------- done
    // A done with no outstanding tag is a protocol violation and is dropped.
    always_comb begin
        done_eff = '0;
        for (int g = 0; g < NumGroups; g++) begin
            done_eff[g] = grp_done_i[g] && !flush_i && (tcnt_q[g] != '0);
        end
    end

    // ---------------------------------------------------------------- arbiter
    // Round-robin starting after the last granted group. A grant that met
    // back-pressure stays locked so the presented result cannot change.
    always_comb begin
        grant     = lock_grp_q;
        grant_vld = lock_q;
        rr_idx    = 0;
        if (!lock_q) begin
            for (int i = 1; i <= NumGroups; i++) begin
                rr_idx = (int'(last_grant_q) + i) % NumGroups;
                if (!grant_vld && (rcnt_q[rr_idx] != '0)) begin
                    grant_vld = 1'b1;
                    grant     = GselW'(rr_idx);
                end
            end
        end
    end

    assign result_valid_o = grant_vld && !flush_i;
    assign res_hs         = result_valid_o && result_ready_i;

    always_comb begin
        result_id_o    = '0;
        result_data_o  = '0;
        result_group_o = '0;
        if (grant_vld) begin
            result_id_o    = rid_mem[grant][rrd_q[grant]];
            result_data_o  = rdat_mem[grant][rrd_q[grant]];
            result_group_o = grant;
        end
    end

    always_comb begin
        res_pop = '0;
        for (int g = 0; g < NumGroups; g++) begin
            res_pop[g] = res_hs && (grant == GselW'(g));
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        cnt_d        = cnt_q;
        tcnt_d       = tcnt_q;
        rcnt_d       = rcnt_q;
        twr_d        = twr_q;
        trd_d        = trd_q;
        rwr_d        = rwr_q;
        rrd_d        = rrd_q;
        lock_d       = lock_q;
        lock_grp_d   = lock_grp_q;
        last_grant_d = last_grant_q;

        if (flush_i) begin
            for (int g = 0; g < NumGroups; g++) begin
                cnt_d[g]  = '0;
                tcnt_d[g] = '0;
                rcnt_d[g] = '0;
                twr_d[g]  = '0;
                trd_d[g]  = '0;
                rwr_d[g]  = '0;
                rrd_d[g]  = '0;
            end
            lock_d       = 1'b0;
            lock_grp_d   = '0;
            last_grant_d = LastGrpIdx;
        end else begin
            for (int g = 0; g < NumGroups; g++) begin
                // An accept and a result handshake on one group cancel out.
                cnt_d[g]  = cnt_q[g] + CntW'(grp_exec_o[g]) - CntW'(res_pop[g]);
                tcnt_d[g] = tcnt_q[g] + CntW'(grp_exec_o[g]) - CntW'(done_eff[g]);
                rcnt_d[g] = rcnt_q[g] + CntW'(done_eff[g]) - CntW'(res_pop[g]);
                if (grp_exec_o[g]) twr_d[g] = ptr_inc(twr_q[g]);
                if (done_eff[g])   trd_d[g] = ptr_inc(trd_q[g]);
                if (done_eff[g])   rwr_d[g] = ptr_inc(rwr_q[g]);
                if (res_pop[g])    rrd_d[g] = ptr_inc(rrd_q[g]);
            end
            if (res_hs) begin
                lock_d       = 1'b0;
                last_grant_d = grant;
            end else if (result_valid_o) begin
                lock_d     = 1'b1;
                lock_grp_d = grant;
            end
        end
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int g = 0; g < NumGroups; g++) begin
                cnt_q[g]  <= '0;
                tcnt_q[g] <= '0;
                rcnt_q[g] <= '0;
                twr_q[g]  <= '0;
                trd_q[g]  <= '0;
                rwr_q[g]  <= '0;
                rrd_q[g]  <= '0;
            end
            lock_q       <= 1'b0;
            lock_grp_q   <= '0;
            last_grant_q <= LastGrpIdx;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            rcnt_q       <= rcnt_d;
            twr_q        <= twr_d;
            trd_q        <= trd_d;
            rwr_q        <= rwr_d;
            rrd_q        <= rrd_d;
            lock_q       <= lock_d;
            lock_grp_q   <= lock_grp_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: storage arrays have no reset; the occupancy counters mark valid entries.
    always_ff @(posedge clk_i) begin
        for (int g = 0; g < NumGroups; g++) begin
            if (grp_exec_o[g]) tag_mem[g][twr_q[g]] <= issue_id_i;
            if (done_eff[g]) begin
                rid_mem[g][rwr_q[g]]  <= tag_mem[g][trd_q[g]];
                rdat_mem[g][rwr_q[g]] <= grp_result_i[g*OutWidth +: OutWidth];
            end
        end
    end

    // A group must not report done without an outstanding instruction.
    for (genvar g = 0; g < NumGroups; g++) begin : g_done_chk
        a_done_has_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (grp_done_i[g] && !flush_i) |-> (tcnt_q[g] != '0));
    end

endmodule

// File: tb/tb_cvxif_group_dispatch.sv
// -----------------------------------------------------------------------------
// tb_cvxif_group_dispatch
//
// Directed bench for cvxif_group_dispatch. The main instance uses the default
// parameters (4 groups, depth 2). A second instance with 3 groups checks the
// reject path for an opcode that selects a missing group. Expected results are
// queued when the bench drives a done; a monitor pops and compares on each
// result handshake.
// -----------------------------------------------------------------------------
module tb_cvxif_group_dispatch;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
        logic [1:0]  grp;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    // Main instance stimulus and observation.
    logic         flush_i          = 1'b0;
    logic         issue_valid_i    = 1'b0;
    logic [7:0]   issue_opcode_i   = '0;
    logic [2:0]   issue_id_i       = '0;
    logic [63:0]  issue_operands_i = '0;
    logic [3:0]   grp_ready_i      = '1;
    logic [3:0]   grp_done_i       = '0;
    logic [127:0] grp_result_i     = '0;
    logic         result_ready_i   = 1'b1;
    logic         issue_ready_o;
    logic         issue_accept_o;
    logic [3:0]   grp_exec_o;
    logic [7:0]   grp_opcode_o;
    logic [63:0]  grp_operands_o;
    logic         grp_flush_o;
    logic         result_valid_o;
    logic [2:0]   result_id_o;
    logic [31:0]  result_data_o;
    logic [1:0]   result_group_o;

    // Three-group instance for the illegal-opcode path.
    logic        d3_valid  = 1'b0;
    logic [7:0]  d3_opcode = '0;
    logic [2:0]  d3_id     = '0;
    logic [2:0]  d3_grp_ready  = '1;
    logic [2:0]  d3_grp_done   = '0;
    logic [95:0] d3_grp_result = '0;
    logic        d3_ready;
    logic        d3_accept;
    logic [2:0]  d3_exec;
    logic [7:0]  d3_grp_opcode;
    logic [63:0] d3_grp_operands;
    logic        d3_grp_flush;
    logic        d3_res_valid;
    logic [2:0]  d3_res_id;
    logic [31:0] d3_res_data;
    logic [1:0]  d3_res_group;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    exp_t e;

    cvxif_group_dispatch u_dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_accept_o   (issue_accept_o),
        .issue_opcode_i   (issue_opcode_i),
        .issue_id_i       (issue_id_i),
        .issue_operands_i (issue_operands_i),
        .grp_exec_o       (grp_exec_o),
        .grp_opcode_o     (grp_opcode_o),
        .grp_operands_o   (grp_operands_o),
        .grp_ready_i      (grp_ready_i),
        .grp_flush_o      (grp_flush_o),
        .grp_done_i       (grp_done_i),
        .grp_result_i     (grp_result_i),
        .result_valid_o   (result_valid_o),
        .result_ready_i   (result_ready_i),
        .result_id_o      (result_id_o),
        .result_data_o    (result_data_o),
        .result_group_o   (result_group_o)
    );

    cvxif_group_dispatch #(.NumGroups(3)) u_dut3 (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (1'b0),
        .issue_valid_i    (d3_valid),
        .issue_ready_o    (d3_ready),
        .issue_accept_o   (d3_accept),
        .issue_opcode_i   (d3_opcode),
        .issue_id_i       (d3_id),
        .issue_operands_i (64'h0),
        .grp_exec_o       (d3_exec),
        .grp_opcode_o     (d3_grp_opcode),
        .grp_operands_o   (d3_grp_operands),
        .grp_ready_i      (d3_grp_ready),
        .grp_flush_o      (d3_grp_flush),
        .grp_done_i       (d3_grp_done),
        .grp_result_i     (d3_grp_result),
        .result_valid_o   (d3_res_valid),
        .result_ready_i   (1'b1),
        .result_id_o      (d3_res_id),
        .result_data_o    (d3_res_data),
        .result_group_o   (d3_res_group)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the next cycle's inputs just after the active edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] id);
        issue_valid_i    = 1'b1;
        issue_opcode_i   = op;
        issue_id_i       = id;
        issue_operands_i = {29'h0, id, 24'h0, op};
    endtask

    task automatic done(input int g, input logic [31:0] v);
        grp_done_i[g]          = 1'b1;
        grp_result_i[g*32 +: 32] = v;
    endtask

    task automatic expect_res(input logic [2:0] id, input logic [31:0] data, input logic [1:0] grp);
        sb.push_back('{id: id, data: data, grp: grp});
    endtask

    // Monitor: every result handshake is compared with the queue head.
    always @(negedge clk_i) begin
        if (rst_ni && result_valid_o && result_ready_i) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got id %0d data %0h grp %0d, expected none",
                         result_id_o, result_data_o, result_group_o);
            end else begin
                e = sb.pop_front();
                check("res_id", 64'(result_id_o), 64'(e.id));
                check("res_data", 64'(result_data_o), 64'(e.data));
                check("res_group", 64'(result_group_o), 64'(e.grp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------------------------------------------------- reset
        issue_opcode_i   = 8'h12;
        issue_operands_i = 64'h0123_4567_89AB_CDEF;
        #2;
        check("rst_issue_ready", 64'(issue_ready_o), 0);
        check("rst_accept", 64'(issue_accept_o), 0);
        check("rst_exec", 64'(grp_exec_o), 0);
        check("rst_result_valid", 64'(result_valid_o), 0);
        check("rst_result_id", 64'(result_id_o), 0);
        check("rst_result_data", 64'(result_data_o), 0);
        check("rst_result_group", 64'(result_group_o), 0);
        check("rst_grp_flush", 64'(grp_flush_o), 0);
        check("rst_opcode_pass", 64'(grp_opcode_o), 64'h12);
        check("rst_operands_pass", grp_operands_o, 64'h0123_4567_89AB_CDEF);
        #20 rst_ni = 1'b1;

        // ------------------------------------------------------ single op
        cyc();
        grp_ready_i = 4'b1101;
        issue(8'h12, 3'd5);
        mid();
        check("single_busy_ready", 64'(issue_ready_o), 0);
        check("single_busy_exec", 64'(grp_exec_o), 0);
        cyc();
        grp_ready_i = '1;
        mid();
        check("single_ready", 64'(issue_ready_o), 1);
        check("single_accept", 64'(issue_accept_o), 1);
        check("single_exec", 64'(grp_exec_o), 64'b0010);
        cyc();
        issue_valid_i = 1'b0;
        cyc();
        cyc();
        done(1, 32'hCAFE);
        expect_res(3'd5, 32'hCAFE, 2'd1);
        mid();
        check("single_no_early_valid", 64'(result_valid_o), 0);
        cyc();
        grp_done_i = '0;
        mid();
        check("single_valid_latency", 64'(result_valid_o), 1);
        cyc();
        mid();
        check("single_drained", 64'(result_valid_o), 0);

        // -------------------------------------------------------- credits
        cyc();
        result_ready_i = 1'b0;
        issue(8'h03, 3'd1);
        mid();
        check("cred_1_exec", 64'(grp_exec_o), 64'b0001);
        cyc();
        issue(8'h03, 3'd2);
        mid();
        check("cred_2_ready", 64'(issue_ready_o), 1);
        cyc();
        issue(8'h03, 3'd3);
        done(0, 32'h100);
        expect_res(3'd1, 32'h100, 2'd0);
        mid();
        check("cred_3_blocked", 64'(issue_ready_o), 0);
        check("cred_3_no_exec", 64'(grp_exec_o), 0);
        cyc();
        done(0, 32'h200);
        expect_res(3'd2, 32'h200, 2'd0);
        mid();
        check("cred_still_blocked", 64'(issue_ready_o), 0);
        check("cred_result_pending", 64'(result_valid_o), 1);
        cyc();
        grp_done_i     = '0;
        result_ready_i = 1'b1;
        mid();
        check("cred_blocked_at_handshake", 64'(issue_ready_o), 0);
        cyc();
        mid();
        check("cred_reasserted", 64'(issue_ready_o), 1);
        check("cred_3_exec", 64'(grp_exec_o), 64'b0001);
        cyc();
        issue(8'h03, 3'd4);
        done(0, 32'h300);
        expect_res(3'd3, 32'h300, 2'd0);
        mid();
        check("cred_same_cycle_kept", 64'(issue_ready_o), 1);
        cyc();
        issue_valid_i = 1'b0;
        grp_done_i    = '0;
        mid();
        check("cred_full_again", 64'(issue_ready_o), 0);
        cyc();
        done(0, 32'h400);
        expect_res(3'd4, 32'h400, 2'd0);
        mid();
        check("cred_one_free", 64'(issue_ready_o), 1);
        cyc();
        grp_done_i = '0;
        cyc();

        // ---------------------------------------------------------- flush
        result_ready_i = 1'b0;
        issue(8'h10, 3'd1);
        cyc();
        issue(8'h20, 3'd2);
        cyc();
        issue(8'h30, 3'd3);
        cyc();
        issue_valid_i = 1'b0;
        done(1, 32'h11);
        done(2, 32'h22);
        cyc();
        grp_done_i = '0;
        mid();
        check("flush_pre_valid", 64'(result_valid_o), 1);
        cyc();
        flush_i = 1'b1;
        done(3, 32'h33);
        issue(8'h10, 3'd4);
        mid();
        check("flush_result_valid", 64'(result_valid_o), 0);
        check("flush_issue_ready", 64'(issue_ready_o), 0);
        check("flush_exec", 64'(grp_exec_o), 0);
        check("flush_forward", 64'(grp_flush_o), 1);
        cyc();
        flush_i        = 1'b0;
        grp_done_i     = '0;
        result_ready_i = 1'b1;
        mid();
        check("post_flush_valid", 64'(result_valid_o), 0);
        check("post_flush_accept", 64'(issue_accept_o), 1);
        check("post_flush_exec", 64'(grp_exec_o), 64'b0010);
        cyc();
        issue(8'h30, 3'd5);
        mid();
        check("post_flush_g3_a", 64'(issue_ready_o), 1);
        cyc();
        issue(8'h30, 3'd6);
        mid();
        check("post_flush_g3_b", 64'(issue_ready_o), 1);
        cyc();
        issue_valid_i = 1'b0;
        done(1, 32'h41);
        done(3, 32'h51);
        expect_res(3'd4, 32'h41, 2'd1);
        expect_res(3'd5, 32'h51, 2'd3);
        cyc();
        grp_done_i = '0;
        done(3, 32'h61);
        expect_res(3'd6, 32'h61, 2'd3);
        cyc();
        grp_done_i = '0;
        cyc();
        cyc();
        cyc();

        // --------------------------------------------------- back-pressure
        result_ready_i = 1'b0;
        issue(8'h20, 3'd6);
        cyc();
        issue(8'h00, 3'd7);
        cyc();
        issue_valid_i = 1'b0;
        done(2, 32'hD2);
        expect_res(3'd6, 32'hD2, 2'd2);
        cyc();
        grp_done_i = '0;
        done(0, 32'hD0);
        expect_res(3'd7, 32'hD0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            mid();
            check("bp_valid", 64'(result_valid_o), 1);
            check("bp_group", 64'(result_group_o), 2);
            check("bp_id", 64'(result_id_o), 6);
            check("bp_data", 64'(result_data_o), 64'hD2);
            cyc();
            grp_done_i = '0;
        end
        result_ready_i = 1'b1;
        cyc();
        cyc();

        // Bridge op on group 3 so the round-robin pointer rests on group 3.
        issue(8'h30, 3'd0);
        cyc();
        issue_valid_i = 1'b0;
        done(3, 32'hE3);
        expect_res(3'd0, 32'hE3, 2'd3);
        cyc();
        grp_done_i = '0;
        cyc();

        // -------------------------------------------------------- fairness
        issue(8'h00, 3'd1);
        cyc();
        issue(8'h10, 3'd2);
        cyc();
        issue(8'h20, 3'd3);
        cyc();
        issue_valid_i = 1'b0;
        done(0, 32'hA0);
        done(1, 32'hA1);
        done(2, 32'hA2);
        expect_res(3'd1, 32'hA0, 2'd0);
        expect_res(3'd2, 32'hA1, 2'd1);
        expect_res(3'd3, 32'hA2, 2'd2);
        cyc();
        grp_done_i = '0;
        cyc();
        cyc();
        cyc();
        issue(8'h00, 3'd4);
        cyc();
        issue(8'h30, 3'd5);
        cyc();
        issue_valid_i = 1'b0;
        done(0, 32'hB0);
        done(3, 32'hB3);
        expect_res(3'd5, 32'hB3, 2'd3);
        expect_res(3'd4, 32'hB0, 2'd0);
        cyc();
        grp_done_i = '0;

        // Bounded drain of the remaining expected results.
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
        check("scoreboard_drained", 64'(sb.size()), 0);
        mid();
        check("final_idle_valid", 64'(result_valid_o), 0);

        // -------------------------------------------- illegal (3 groups)
        cyc();
        d3_valid  = 1'b1;
        d3_opcode = 8'h30;
        d3_id     = 3'd1;
        mid();
        check("illegal_ready", 64'(d3_ready), 1);
        check("illegal_accept", 64'(d3_accept), 0);
        check("illegal_exec", 64'(d3_exec), 0);
        cyc();
        d3_opcode = 8'h00;
        d3_id     = 3'd2;
        mid();
        check("legal3_a_accept", 64'(d3_accept), 1);
        check("legal3_a_exec", 64'(d3_exec), 64'b001);
        cyc();
        d3_id = 3'd3;
        mid();
        check("legal3_b_accept", 64'(d3_accept), 1);
        cyc();
        d3_id = 3'd4;
        mid();
        check("legal3_full", 64'(d3_ready), 0);
        check("legal3_no_result", 64'(d3_res_valid), 0);
        cyc();
        d3_valid = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
